// File: rtl/ge_p1p1_convert_pkg.sv
// Shared types, job sizes and the product schedule for the ge_p1p1 converter.
package ge_p1p1_convert_pkg;

    localparam int FE_WIDTH   = 320;
    localparam int FE_LIMBS   = 10;
    localparam int FE_MUL_LAT = 3;
    localparam int N_P2       = 3;
    localparam int N_P3       = 4;

    typedef logic signed [FE_WIDTH-1:0] fe_t;

    typedef enum logic {
        GE_P2 = 1'b0,
        GE_P3 = 1'b1
    } ge_form_e;

    typedef enum logic [1:0] {
        PROD_X = 2'd0,
        PROD_Y = 2'd1,
        PROD_Z = 2'd2,
        PROD_T = 2'd3
    } prod_e;

    typedef struct packed {
        logic  valid;
        prod_e prod;
    } sched_t;

    function automatic int n_prod(input ge_form_e form);
        return (form == GE_P3) ? N_P3 : N_P2;
    endfunction

    function automatic int n_groups(input ge_form_e form, input int num_mul);
        return (n_prod(form) + num_mul - 1) / num_mul;
    endfunction

    // Products are dealt out in X,Y,Z,T order, num_mul at a time.
    function automatic sched_t sched(input logic [1:0] group, input int lane,
                                     input ge_form_e form, input int num_mul);
        sched_t s;
        int     idx;
        idx     = int'(group) * num_mul + lane;
        s.valid = (idx < n_prod(form));
        s.prod  = prod_e'(idx[1:0]);
        return s;
    endfunction

endpackage

// File: rtl/ge_p1p1_convert_fe_mul.sv
// Field multiply h = f*g in the 10-limb radix-2^25.5 representation,
// bit-exact with the ref10 schoolbook product and carry chain.
// h is valid while done_o is high, LAT cycles after start_i.
module ge_p1p1_convert_fe_mul
    import ge_p1p1_convert_pkg::*;
#(
    parameter int LAT = FE_MUL_LAT
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  fe_t  f_i,
    input  fe_t  g_i,
    output logic done_o,
    output fe_t  h_o
);

    // Carry order of the ref10 reduction, step 0 in the low nibble.
    localparam logic [47:0] CARRY_ORDER = {4'd0, 4'd9, 4'd8, 4'd4, 4'd7, 4'd3,
                                           4'd6, 4'd2, 4'd5, 4'd1, 4'd4, 4'd0};

    function automatic fe_t mul_ref10(input fe_t f, input fe_t g);
        logic signed [63:0] acc [FE_LIMBS];
        logic signed [63:0] prod;
        logic signed [63:0] carry;
        int                 k;
        int                 sh;
        fe_t                h;
        for (int n = 0; n < FE_LIMBS; n++) acc[n] = '0;
        for (int i = 0; i < FE_LIMBS; i++) begin
            for (int j = 0; j < FE_LIMBS; j++) begin
                prod = 64'(signed'(f[i*32 +: 32])) * 64'(signed'(g[j*32 +: 32]));
                if ((i % 2 == 1) && (j % 2 == 1)) prod = prod <<< 1;
                if (i + j >= FE_LIMBS) prod = prod * 64'sd19;
                acc[(i + j) % FE_LIMBS] = acc[(i + j) % FE_LIMBS] + prod;
            end
        end
        for (int step = 0; step < 12; step++) begin
            k      = int'(CARRY_ORDER[step*4 +: 4]);
            sh     = (k % 2 == 0) ? 26 : 25;
            carry  = (acc[k] + (64'sd1 <<< (sh - 1))) >>> sh;
            acc[k] = acc[k] - (carry <<< sh);
            if (k == FE_LIMBS - 1) acc[0] = acc[0] + carry * 64'sd19;
            else                   acc[k + 1] = acc[k + 1] + carry;
        end
        for (int n = 0; n < FE_LIMBS; n++) h[n*32 +: 32] = acc[n][31:0];
        return h;
    endfunction

    fe_t        h_q;
    logic [3:0] cnt_q;

    // Latch the product at start, then count down to the done cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_q   <= '0;
            cnt_q <= '0;
        end else if (start_i) begin
            h_q   <= mul_ref10(f_i, g_i);
            cnt_q <= 4'(LAT);
        end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign done_o = (cnt_q == 4'd1);
    assign h_o    = h_q;

endmodule

// File: rtl/ge_p1p1_convert.sv
// ge_p1p1 -> ge_p2 / ge_p3 conversion using NUM_MUL parallel fe_mul lanes.
//
// state  | meaning
// IDLE   | waiting for start; captures operands and form on acceptance
// ISSUE  | starts every lane that owns a product in the current group
// WAIT   | collects lane results; next group or finish once all flagged
// DONE   | one-cycle done pulse, results valid
module ge_p1p1_convert
    import ge_p1p1_convert_pkg::*;
#(
    parameter int FE_W    = 320,
    parameter int NUM_MUL = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            mode,
    input  logic [FE_W-1:0] p_X,
    input  logic [FE_W-1:0] p_Y,
    input  logic [FE_W-1:0] p_Z,
    input  logic [FE_W-1:0] p_T,
    output logic            busy,
    output logic            done,
    output logic [FE_W-1:0] r_X,
    output logic [FE_W-1:0] r_Y,
    output logic [FE_W-1:0] r_Z,
    output logic [FE_W-1:0] r_T
);

    if (NUM_MUL != 1 && NUM_MUL != 2) begin : g_bad_num_mul
        $error("ge_p1p1_convert: NUM_MUL must be 1 or 2");
    end
    if (FE_W != FE_WIDTH) begin : g_bad_fe_w
        $error("ge_p1p1_convert: FE_W must equal the 10-limb field width");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

    state_e               state_q;
    ge_form_e             form_q;
    fe_t                  px_q, py_q, pz_q, pt_q;
    logic [1:0]           grp_q, last_grp_q;
    logic [NUM_MUL-1:0]   lane_flag_q;
    fe_t                  r_x_q, r_y_q, r_z_q, r_t_q;
    logic                 busy_q, done_q;

    logic [NUM_MUL-1:0]   lane_active, lane_start, lane_done;
    prod_e                lane_prod [NUM_MUL];
    fe_t                  lane_h    [NUM_MUL];
    logic                 all_done_d;

    for (genvar l = 0; l < NUM_MUL; l++) begin : g_lane
        sched_t sc;
        fe_t    op_f, op_g;

        assign sc             = sched(grp_q, l, form_q, NUM_MUL);
        assign lane_active[l] = sc.valid;
        assign lane_prod[l]   = sc.prod;
        assign lane_start[l]  = (state_q == S_ISSUE) && sc.valid;

        // Operand pair for the product this lane owns in the current group.
        always_comb begin
            op_f = px_q;
            op_g = pt_q;
            case (sc.prod)
                PROD_X: begin op_f = px_q; op_g = pt_q; end
                PROD_Y: begin op_f = py_q; op_g = pz_q; end
                PROD_Z: begin op_f = pz_q; op_g = pt_q; end
                PROD_T: begin op_f = px_q; op_g = py_q; end
            endcase
        end

        ge_p1p1_convert_fe_mul u_fe_mul (
            .clk     (clk),
            .reset   (reset),
            .start_i (lane_start[l]),
            .f_i     (op_f),
            .g_i     (op_g),
            .done_o  (lane_done[l]),
            .h_o     (lane_h[l])
        );
    end

    // A lane counts as finished if flagged earlier, finishing now, or idle.
    assign all_done_d = &(lane_flag_q | lane_done | ~lane_active);

    // Job sequencing, operand capture and result collection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            form_q      <= GE_P2;
            px_q        <= '0;
            py_q        <= '0;
            pz_q        <= '0;
            pt_q        <= '0;
            grp_q       <= '0;
            last_grp_q  <= '0;
            lane_flag_q <= '0;
            r_x_q       <= '0;
            r_y_q       <= '0;
            r_z_q       <= '0;
            r_t_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        px_q       <= p_X;
                        py_q       <= p_Y;
                        pz_q       <= p_Z;
                        pt_q       <= p_T;
                        form_q     <= ge_form_e'(mode);
                        grp_q      <= '0;
                        last_grp_q <= 2'(n_groups(ge_form_e'(mode), NUM_MUL) - 1);
                        if (ge_form_e'(mode) == GE_P2) r_t_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    lane_flag_q <= '0;
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    for (int l = 0; l < NUM_MUL; l++) begin
                        if (lane_active[l] && lane_done[l]) begin
                            lane_flag_q[l] <= 1'b1;
                            case (lane_prod[l])
                                PROD_X: r_x_q <= lane_h[l];
                                PROD_Y: r_y_q <= lane_h[l];
                                PROD_Z: r_z_q <= lane_h[l];
                                PROD_T: r_t_q <= lane_h[l];
                            endcase
                        end
                    end
                    if (all_done_d) begin
                        if (grp_q == last_grp_q) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            grp_q   <= grp_q + 2'd1;
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign r_X  = r_x_q;
    assign r_Y  = r_y_q;
    assign r_Z  = r_z_q;
    assign r_T  = r_t_q;

endmodule

// File: tb/tb_ge_p1p1_convert.sv
// Bench for ge_p1p1_convert: one NUM_MUL=1 and one NUM_MUL=2 instance
// driven with identical stimulus and checked against a ref10-style model.
module tb_ge_p1p1_convert;
    import ge_p1p1_convert_pkg::*;

    localparam int L = FE_MUL_LAT;

    logic         clk = 1'b0;
    logic         reset, start, mode;
    logic [319:0] p_X, p_Y, p_Z, p_T;
    logic         busy_a [2];
    logic         done_a [2];
    logic [319:0] rX [2], rY [2], rZ [2], rT [2];

    int vectors = 0;
    int errs    = 0;
    int cyc     = 0;
    int dcnt [2] = '{0, 0};

    int           o_lat       [2];
    bit           o_busy_ok   [2];
    logic         o_done_busy [2];
    logic [319:0] o_r [2][4];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done_a[0] === 1'b1) dcnt[0] <= dcnt[0] + 1;
        if (done_a[1] === 1'b1) dcnt[1] <= dcnt[1] + 1;
    end

    ge_p1p1_convert #(.FE_W(320), .NUM_MUL(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .p_X(p_X), .p_Y(p_Y), .p_Z(p_Z), .p_T(p_T),
        .busy(busy_a[0]), .done(done_a[0]),
        .r_X(rX[0]), .r_Y(rY[0]), .r_Z(rZ[0]), .r_T(rT[0])
    );

    ge_p1p1_convert #(.FE_W(320), .NUM_MUL(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .p_X(p_X), .p_Y(p_Y), .p_Z(p_Z), .p_T(p_T),
        .busy(busy_a[1]), .done(done_a[1]),
        .r_X(rX[1]), .r_Y(rY[1]), .r_Z(rZ[1]), .r_T(rT[1])
    );

    // ---------------- reference model ----------------
    function automatic longint rnd_carry(input longint v, input int sh);
        return (v + (longint'(1) <<< (sh - 1))) >>> sh;
    endfunction

    function automatic logic [319:0] ref_mul(input logic [319:0] f, input logic [319:0] g);
        longint fl [10], gl [10], f2 [10], g19 [10], h [10];
        longint c;
        int     j;
        logic [319:0] r;
        for (int i = 0; i < 10; i++) begin
            fl[i]  = longint'($signed(f[i*32 +: 32]));
            gl[i]  = longint'($signed(g[i*32 +: 32]));
            f2[i]  = (i % 2 == 1) ? 2 * fl[i] : fl[i];
            g19[i] = 19 * gl[i];
        end
        for (int k = 0; k < 10; k++) begin
            h[k] = 0;
            for (int i = 0; i < 10; i++) begin
                j = (k - i + 10) % 10;
                h[k] += ((j % 2 == 1) ? f2[i] : fl[i]) * ((i > k) ? g19[j] : gl[j]);
            end
        end
        c = rnd_carry(h[0], 26); h[1] += c; h[0] -= c * 64'sd67108864;
        c = rnd_carry(h[4], 26); h[5] += c; h[4] -= c * 64'sd67108864;
        c = rnd_carry(h[1], 25); h[2] += c; h[1] -= c * 64'sd33554432;
        c = rnd_carry(h[5], 25); h[6] += c; h[5] -= c * 64'sd33554432;
        c = rnd_carry(h[2], 26); h[3] += c; h[2] -= c * 64'sd67108864;
        c = rnd_carry(h[6], 26); h[7] += c; h[6] -= c * 64'sd67108864;
        c = rnd_carry(h[3], 25); h[4] += c; h[3] -= c * 64'sd33554432;
        c = rnd_carry(h[7], 25); h[8] += c; h[7] -= c * 64'sd33554432;
        c = rnd_carry(h[4], 26); h[5] += c; h[4] -= c * 64'sd67108864;
        c = rnd_carry(h[8], 26); h[9] += c; h[8] -= c * 64'sd67108864;
        c = rnd_carry(h[9], 25); h[0] += c * 19; h[9] -= c * 64'sd33554432;
        c = rnd_carry(h[0], 26); h[1] += c; h[0] -= c * 64'sd67108864;
        for (int i = 0; i < 10; i++) r[i*32 +: 32] = h[i][31:0];
        return r;
    endfunction

    function automatic logic [319:0] rand_fe();
        logic [319:0] v;
        int           limb;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) limb = int'($urandom_range(0, 32'h03FF_FFFF)) - 33554432;
            else            limb = int'($urandom_range(0, 32'h01FF_FFFF)) - 16777216;
            v[i*32 +: 32] = limb;
        end
        return v;
    endfunction

    function automatic int exp_lat(input int num_mul, input bit p3);
        int n;
        n = p3 ? 4 : 3;
        return ((n + num_mul - 1) / num_mul) * (1 + L) + 1;
    endfunction

    // Launch one job and record what each instance produced.
    task automatic run_job(input bit m, input logic [319:0] x, input logic [319:0] y,
                           input logic [319:0] z, input logic [319:0] t, input bit disturb);
        int t0, rel;
        bit seen [2];
        p_X = x; p_Y = y; p_Z = z; p_T = t; mode = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
        for (int d = 0; d < 2; d++) begin
            seen[d] = 1'b0; o_lat[d] = 0; o_busy_ok[d] = 1'b1; o_done_busy[d] = 1'bx;
        end
        for (int k = 0; k < 60; k++) begin
            rel = cyc - t0 + 1;
            for (int d = 0; d < 2; d++) begin
                if (!seen[d]) begin
                    if (done_a[d] === 1'b1) begin
                        seen[d] = 1'b1;
                        o_lat[d] = rel;
                        o_done_busy[d] = busy_a[d];
                        o_r[d][0] = rX[d]; o_r[d][1] = rY[d];
                        o_r[d][2] = rZ[d]; o_r[d][3] = rT[d];
                    end else if (busy_a[d] !== 1'b1) begin
                        o_busy_ok[d] = 1'b0;
                    end
                end
            end
            if (seen[0] && seen[1]) break;
            if (disturb && rel == 3) begin
                start = 1'b1; mode = ~m;
                p_X = rand_fe(); p_Y = rand_fe(); p_Z = rand_fe(); p_T = rand_fe();
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic check_job(input string nm, input bit m, input logic [319:0] e [4]);
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (o_lat[d] != exp_lat(d + 1, m)) begin
                errs++;
                $display("FAIL %s latency num_mul=%0d: got %0d want %0d", nm, d + 1, o_lat[d], exp_lat(d + 1, m));
            end
            for (int c = 0; c < 4; c++) begin
                vectors++;
                if (o_r[d][c] !== e[c]) begin
                    errs++;
                    $display("FAIL %s coord%0d num_mul=%0d: got %h want %h", nm, c, d + 1, o_r[d][c], e[c]);
                end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; start = 1'b0; mode = 1'b0;
        p_X = '0; p_Y = '0; p_Z = '0; p_T = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if ({busy_a[d], done_a[d]} !== 2'b00 || rX[d] !== '0 || rY[d] !== '0 ||
                rZ[d] !== '0 || rT[d] !== '0) begin
                errs++;
                $display("FAIL reset_state num_mul=%0d: busy=%b done=%b rX=%h rT=%h want all 0",
                         d + 1, busy_a[d], done_a[d], rX[d][31:0], rT[d][31:0]);
            end
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_small(input bit m);
        logic [319:0] e [4];
        e[0] = 320'd14; e[1] = 320'd15; e[2] = 320'd35; e[3] = m ? 320'd6 : 320'd0;
        run_job(m, 320'd2, 320'd3, 320'd5, 320'd7, 1'b0);
        check_job(m ? "small_p3" : "small_p2", m, e);
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (o_busy_ok[d] !== 1'b1 || o_done_busy[d] !== 1'b0) begin
                errs++;
                $display("FAIL busy_window num_mul=%0d: busy_ok=%b busy_at_done=%b want 1/0",
                         d + 1, o_busy_ok[d], o_done_busy[d]);
            end
        end
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_ignore_during_wait();
        logic [319:0] x, y, z, t;
        logic [319:0] e [4];
        int           c0 [2];
        x = rand_fe(); y = rand_fe(); z = rand_fe(); t = rand_fe();
        e[0] = ref_mul(x, t); e[1] = ref_mul(y, z); e[2] = ref_mul(z, t); e[3] = ref_mul(x, y);
        c0 = dcnt;
        run_job(1'b1, x, y, z, t, 1'b1);
        check_job("ignore_wait", 1'b1, e);
        repeat (25) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (dcnt[d] - c0[d] != 1 || busy_a[d] !== 1'b0) begin
                errs++;
                $display("FAIL ignore_wait_count num_mul=%0d: dones=%0d busy=%b want 1/0",
                         d + 1, dcnt[d] - c0[d], busy_a[d]);
            end
        end
    endtask

    task automatic test_reset_mid_job();
        logic [319:0] x, y, z, t;
        logic [319:0] e [4];
        int           c0 [2];
        x = rand_fe(); y = rand_fe(); z = rand_fe(); t = rand_fe();
        c0 = dcnt;
        p_X = x; p_Y = y; p_Z = z; p_T = t; mode = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if ({busy_a[d], done_a[d]} !== 2'b00 || rX[d] !== '0 || rY[d] !== '0 ||
                rZ[d] !== '0 || rT[d] !== '0) begin
                errs++;
                $display("FAIL reset_mid_outputs num_mul=%0d: busy=%b done=%b rX=%h want all 0",
                         d + 1, busy_a[d], done_a[d], rX[d][31:0]);
            end
        end
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (dcnt[d] != c0[d] || rX[d] !== '0 || rT[d] !== '0) begin
                errs++;
                $display("FAIL reset_mid_no_done num_mul=%0d: dones=%0d rX=%h want 0 dones, 0",
                         d + 1, dcnt[d] - c0[d], rX[d][31:0]);
            end
        end
        x = rand_fe(); y = rand_fe(); z = rand_fe(); t = rand_fe();
        e[0] = ref_mul(x, t); e[1] = ref_mul(y, z); e[2] = ref_mul(z, t); e[3] = '0;
        run_job(1'b0, x, y, z, t, 1'b0);
        check_job("after_reset_p2", 1'b0, e);
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [319:0] x, y, z, t;
        logic [319:0] e [4];
        int           dc [2][2];
        int           nd [2];
        logic         busy_after [2];
        logic [319:0] r2 [2][4];
        bit           m;
        m = 1'($urandom_range(0, 1));
        x = rand_fe(); y = rand_fe(); z = rand_fe(); t = rand_fe();
        e[0] = ref_mul(x, t); e[1] = ref_mul(y, z); e[2] = ref_mul(z, t);
        e[3] = m ? ref_mul(x, y) : '0;
        nd = '{0, 0};
        busy_after = '{1'bx, 1'bx};
        p_X = x; p_Y = y; p_Z = z; p_T = t; mode = m; start = 1'b1;
        for (int k = 0; k < 100 && !(nd[0] >= 2 && nd[1] >= 2); k++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                if (nd[d] == 1 && cyc == dc[d][0] + 1) busy_after[d] = busy_a[d];
                if (nd[d] < 2 && done_a[d] === 1'b1) begin
                    dc[d][nd[d]] = cyc;
                    if (nd[d] == 1) begin
                        r2[d][0] = rX[d]; r2[d][1] = rY[d]; r2[d][2] = rZ[d]; r2[d][3] = rT[d];
                    end
                    nd[d]++;
                end
            end
        end
        start = 1'b0;
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (nd[d] < 2 || dc[d][1] - dc[d][0] != exp_lat(d + 1, m) + 1 || busy_after[d] !== 1'b0) begin
                errs++;
                $display("FAIL back_to_back_timing num_mul=%0d: dones=%0d gap=%0d busy_after_done=%b want 2/%0d/0",
                         d + 1, nd[d], (nd[d] < 2) ? -1 : dc[d][1] - dc[d][0], busy_after[d],
                         exp_lat(d + 1, m) + 1);
            end
            for (int c = 0; c < 4; c++) begin
                vectors++;
                if (nd[d] < 2 || r2[d][c] !== e[c]) begin
                    errs++;
                    $display("FAIL back_to_back_coord%0d num_mul=%0d: got %h want %h",
                             c, d + 1, r2[d][c], e[c]);
                end
            end
        end
        repeat (25) @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [319:0] x, y, z, t;
        logic [319:0] e [4];
        bit           m;
        for (int n = 0; n < 10; n++) begin
            m = 1'($urandom_range(0, 1));
            x = rand_fe(); y = rand_fe(); z = rand_fe(); t = rand_fe();
            e[0] = ref_mul(x, t); e[1] = ref_mul(y, z); e[2] = ref_mul(z, t);
            e[3] = m ? ref_mul(x, y) : '0;
            run_job(m, x, y, z, t, 1'b0);
            check_job("random", m, e);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_small(1'b0);
        test_small(1'b1);
        test_ignore_during_wait();
        test_reset_mid_job();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
